// File: rtl/mm_tile_scheduler.sv
// ---------------------------------------------------------------------------
// mm_tile_scheduler
//
// Sequences a large matrix multiply C = A * B onto one sum-stationary NxN
// array, one NxN output tile at a time, in row-major tile order.
//   - Walks (m_idx, p_idx, k_idx) and presents the operand-buffer read
//     addresses {m_idx, k_idx} / {p_idx, k_idx}. The buffers read
//     combinationally, so the address and the valid go out in the same cycle.
//   - Drives the array input handshake and holds the reduction length.
//   - Records the coordinates of every tile fed into the array in a small tag
//     FIFO and attaches them to the N output beats the array returns per tile.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   start                one-cycle pulse: latch cfg_* and begin a job
//   cfg_m_tiles/p_tiles  number of row / column tiles (M, P)
//   cfg_len              reduction length K
//   cfg_by_row           output direction forwarded to the array
//   busy, done, cfg_err  job in progress / end-of-job pulse / rejected start
//   a_rd_addr, b_rd_addr operand-buffer read addresses
//   arr_a_valid/b_valid  array input valids (always equal)
//   arr_input_ready      array input ready
//   arr_len              latched K, held for the whole job
//   arr_output_by_row    latched cfg_by_row
//   arr_output_valid     array output valid
//   arr_output_ready     array output ready (follows sink_ready)
//   sink_ready           result-writer ready
//   out_valid            array output valid qualified by busy
//   out_tile_m/p         tag of the tile being streamed
//   out_row_idx          row/column index of the beat within the tile
//   out_last             final beat of the job
// ---------------------------------------------------------------------------
module mm_tile_scheduler #(
  parameter int N            = 4,
  parameter int COUNTER_BITS = 16,
  parameter int TILE_BITS    = 8,
  parameter int TAG_DEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [TILE_BITS-1:0]          cfg_m_tiles,
  input  logic [TILE_BITS-1:0]          cfg_p_tiles,
  input  logic [COUNTER_BITS-1:0]       cfg_len,
  input  logic                          cfg_by_row,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output logic [TILE_BITS+COUNTER_BITS-1:0] a_rd_addr,
  output logic [TILE_BITS+COUNTER_BITS-1:0] b_rd_addr,
  output logic                          arr_a_valid,
  output logic                          arr_b_valid,
  input  logic                          arr_input_ready,
  output logic [COUNTER_BITS-1:0]       arr_len,
  output logic                          arr_output_by_row,
  input  logic                          arr_output_valid,
  output logic                          arr_output_ready,
  input  logic                          sink_ready,
  output logic                          out_valid,
  output logic [TILE_BITS-1:0]          out_tile_m,
  output logic [TILE_BITS-1:0]          out_tile_p,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_row_idx,
  output logic                          out_last
);

  localparam int ROW_BITS = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_BITS = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_BITS = $clog2(TAG_DEPTH + 1);
  localparam int TAG_BITS = 2 * TILE_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  logic [TILE_BITS-1:0]    r_m_tiles;
  logic [TILE_BITS-1:0]    r_p_tiles;
  logic [COUNTER_BITS-1:0] r_len;
  logic                    r_by_row;
  logic [TILE_BITS-1:0]    r_m_idx;
  logic [TILE_BITS-1:0]    r_p_idx;
  logic [COUNTER_BITS-1:0] r_k_idx;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_cfg_err;

  // Tag FIFO: one {m, p} entry per tile that has been fully fed into the
  // array but whose N output beats have not all left yet.
  logic [TAG_BITS-1:0]     r_tag_mem [TAG_DEPTH];
  logic [PTR_BITS-1:0]     r_wr_ptr;
  logic [PTR_BITS-1:0]     r_rd_ptr;
  logic [CNT_BITS-1:0]     r_fifo_cnt;
  logic [ROW_BITS-1:0]     r_beat;

  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic                    w_in_valid;
  logic                    w_in_fire;
  logic                    w_tile_end;
  logic                    w_last_p;
  logic                    w_last_tile;
  logic                    w_out_valid;
  logic                    w_out_fire;
  logic                    w_beat_last;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_cfg_bad;
  logic [TAG_BITS-1:0]     w_head;

  function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_fifo_full  = (r_fifo_cnt == CNT_BITS'(TAG_DEPTH));
  assign w_fifo_empty = (r_fifo_cnt == '0);

  // Pushes only happen on the final beat of a tile, after which k_idx is 0.
  // Gating on k_idx == 0 therefore only ever holds the feed at a tile
  // boundary: a tile is never split across a stall.
  assign w_in_valid  = (r_state == S_FEED) && !(w_fifo_full && (r_k_idx == '0));
  assign w_in_fire   = w_in_valid && arr_input_ready;
  assign w_tile_end  = w_in_fire && (r_k_idx == r_len - 1'b1);
  assign w_last_p    = (r_p_idx == r_p_tiles - 1'b1);
  assign w_last_tile = w_last_p && (r_m_idx == r_m_tiles - 1'b1);

  assign w_out_valid = arr_output_valid && r_busy;
  assign w_out_fire  = w_out_valid && sink_ready;
  assign w_beat_last = (r_beat == ROW_BITS'(N - 1));
  assign w_push      = w_tile_end;
  assign w_pop       = w_out_fire && w_beat_last && !w_fifo_empty;

  assign w_cfg_bad   = (cfg_m_tiles == '0) || (cfg_p_tiles == '0) || (cfg_len == '0);
  assign w_head      = r_tag_mem[r_rd_ptr];

  // Control: FSM, job configuration, tile walk, FIFO pointers, beat counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_m_tiles  <= '0;
      r_p_tiles  <= '0;
      r_len      <= '0;
      r_by_row   <= 1'b0;
      r_m_idx    <= '0;
      r_p_idx    <= '0;
      r_k_idx    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_beat     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;

      if (w_out_fire) begin
        r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
      end

      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_m_tiles <= cfg_m_tiles;
              r_p_tiles <= cfg_p_tiles;
              r_len     <= cfg_len;
              r_by_row  <= cfg_by_row;
              r_m_idx   <= '0;
              r_p_idx   <= '0;
              r_k_idx   <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_FEED;
            end
          end
        end

        S_FEED: begin
          if (w_in_fire) begin
            if (w_tile_end) begin
              r_k_idx <= '0;
              if (w_last_tile) begin
                r_m_idx <= '0;
                r_p_idx <= '0;
                r_state <= S_DRAIN;
              end else if (w_last_p) begin
                r_p_idx <= '0;
                r_m_idx <= r_m_idx + 1'b1;
              end else begin
                r_p_idx <= r_p_idx + 1'b1;
              end
            end else begin
              r_k_idx <= r_k_idx + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          // Only the final tile's tag is left when the count is 1 here.
          if (w_pop && (r_fifo_cnt == CNT_BITS'(1))) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag storage: data only, validity is tracked by the FIFO count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= {r_m_idx, r_p_idx};
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign cfg_err           = r_cfg_err;
  assign a_rd_addr         = {r_m_idx, r_k_idx};
  assign b_rd_addr         = {r_p_idx, r_k_idx};
  assign arr_a_valid       = w_in_valid;
  assign arr_b_valid       = w_in_valid;
  assign arr_len           = r_len;
  assign arr_output_by_row = r_by_row;
  assign arr_output_ready  = sink_ready;
  assign out_valid         = w_out_valid;
  // Tag memory is not reset; an empty FIFO presents a zero tag instead.
  assign out_tile_m        = w_fifo_empty ? '0 : w_head[TAG_BITS-1:TILE_BITS];
  assign out_tile_p        = w_fifo_empty ? '0 : w_head[TILE_BITS-1:0];
  assign out_row_idx       = r_beat;
  assign out_last          = w_out_valid && w_beat_last &&
                             (r_fifo_cnt == CNT_BITS'(1)) && (r_state == S_DRAIN);

  // An output beat with no outstanding tile means the array and this
  // scheduler disagree about how many tiles are in flight.
  a_no_orphan_output : assert property (@(posedge clk) disable iff (!reset)
    !(w_out_valid && w_fifo_empty));

endmodule
